cg_rvarch_sv39_tlb: RTL
=======================

CG_RVARCH_SV39_TLB -- requirements
Module: cg_rvarch_sv39_tlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of fully associative entries (power of two, >=2).
REQ-002 SHALL have parameter VADDR_WIDTH, default 39, virtual address width.
REQ-003 SHALL have parameter PADDR_WIDTH, default 56, physical address width.
REQ-004 SHALL have parameter ATTR_WIDTH, default 11, PTE attribute width {N,PBMT[1:0],D,A,G,U,X,W,R,V}.
REQ-005 SHALL have port i_clk  in  1  the only clock; all logic on rising edge.
REQ-006 SHALL have port i_rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_req_valid  in  1  core translation request.
REQ-008 SHALL have port i_req_vaddr  in  VADDR_WIDTH  virtual address to translate.
REQ-009 SHALL have port o_req_ready  out  1  request accepted this cycle when high with i_req_valid.
REQ-010 SHALL have port o_resp_valid  out  1  one-cycle response strobe.
REQ-011 SHALL have port o_resp_paddr  out  PADDR_WIDTH  translated physical address.
REQ-012 SHALL have port o_resp_attr  out  ATTR_WIDTH  attributes of the translation.
REQ-013 SHALL have port o_resp_fault  out  1  translation faulted; paddr/attr don't-care.
REQ-014 SHALL have port i_flush  in  1  invalidate all entries (sfence.vma).
REQ-015 SHALL have ports o_tlb_miss (out 1) and o_tlb_miss_vaddr (out VADDR_WIDTH) toward the walker.
REQ-016 SHALL have ports i_ptw_valid (in 1), i_ptw_paddr (in PADDR_WIDTH), i_ptw_pte_attr (in ATTR_WIDTH), i_page_fault (in 1) from the walker.

Function
REQ-017 SHALL store per entry: valid, VPN = vaddr[38:12], PPN = paddr[55:12], attr; all fills are 4 KiB granularity.
REQ-018 SHALL implement states IDLE, MISS, WAIT; o_req_ready = 1 only in IDLE.
REQ-019 SHALL, on accept in IDLE with a VPN hit, stay in IDLE and assert o_resp_valid the next cycle with paddr = {PPN, vaddr[11:0]}, attr, fault=0; back-to-back hits give one response per cycle.
REQ-020 SHALL, on multiple matching entries, use the lowest index.
REQ-021 SHALL, on accept with a miss, latch vaddr and go IDLE->MISS.
REQ-022 SHALL assert o_tlb_miss for exactly the one MISS cycle, then go to WAIT.
REQ-023 SHALL hold o_tlb_miss_vaddr stable at the latched vaddr from MISS through leaving WAIT.
REQ-024 SHALL, in WAIT, treat the walker result as complete only on a rising edge of i_ptw_valid (high now, low the previous cycle), because the walker holds valid high between walks.
REQ-025 SHALL, on completion, write the entry at the victim pointer, assert o_resp_valid next cycle with paddr = i_ptw_paddr, attr = i_ptw_pte_attr, fault=0, and return to IDLE.
REQ-026 SHALL keep the victim pointer as a log2(ENTRIES)-bit round-robin counter, incremented per fill and wrapping ENTRIES-1 -> 0; an invalid entry, lowest index first, is chosen before the pointer.
REQ-027 SHALL, if i_page_fault is high in WAIT, respond with fault=1 next cycle, perform no fill, and return to IDLE; page fault has priority over a simultaneous valid edge.
REQ-028 SHALL, on i_flush, clear all valid bits at the next edge; a request accepted in the same cycle as the flush is looked up against pre-flush contents.
REQ-029 SHALL, on a flush during WAIT or coinciding with completion, still return the response but skip the fill write.
REQ-030 SHALL register o_resp_* so they change only at clock edges; o_resp_valid is never high two cycles for one miss.

Reset
REQ-031 SHALL, on i_rstn low (any time, mid-walk included), set state IDLE, all entries invalid, victim pointer 0, o_resp_valid 0, o_resp_fault 0, o_resp_paddr 0, o_resp_attr 0, o_tlb_miss 0, o_tlb_miss_vaddr 0, and the previous-i_ptw_valid register 1 (suppresses a stale edge).

Configuration
REQ-032 SHALL, with macro CG_TLB_PERF_CNT_EN defined, add outputs o_hit_cnt and o_miss_cnt (32 bits each, reset 0, wrap at 2^32): +1 per accepted hit and per accepted miss respectively.
REQ-033 SHALL, without CG_TLB_PERF_CNT_EN, omit those ports and counters, with identical behaviour otherwise.

Verification
REQ-034 SHALL cover: reset, req vaddr 0x0_1234_5678 -> miss pulse 1 cycle, vaddr held; walker edge paddr 0x80_0000_0678, attr 0x0CF -> resp paddr 0x80_0000_0678, fault 0.
REQ-035 SHALL cover: same vaddr repeated 3 back-to-back -> 3 hits, resp each cycle, no o_tlb_miss; perf counters read hit=3, miss=1.
REQ-036 SHALL cover: ENTRIES+1 distinct-page misses -> last fill overwrites entry 0; the first page then misses again.
REQ-037 SHALL cover: i_ptw_valid held high from the previous walk while in WAIT -> no fill until a low-then-high edge.
REQ-038 SHALL cover: i_page_fault in WAIT -> resp fault=1, no entry written; retry of the same vaddr misses again.
REQ-039 SHALL cover: i_flush during WAIT, then completion -> response returned; entries empty; the next lookup of that vaddr misses.

Source files
------------

// File: rtl/cg_rvarch_sv39_tlb.sv
// Fully associative Sv39 TLB (4 KiB fills) with one outstanding miss handed to a page walker.
// Define CG_TLB_PERF_CNT_EN to add hit/miss performance counters.
module cg_rvarch_sv39_tlb #(
    parameter int ENTRIES     = 8,
    parameter int VADDR_WIDTH = 39,
    parameter int PADDR_WIDTH = 56,
    parameter int ATTR_WIDTH  = 11
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_req_valid,
    input  logic [VADDR_WIDTH-1:0] i_req_vaddr,
    output logic                   o_req_ready,
    output logic                   o_resp_valid,
    output logic [PADDR_WIDTH-1:0] o_resp_paddr,
    output logic [ATTR_WIDTH-1:0]  o_resp_attr,
    output logic                   o_resp_fault,
    input  logic                   i_flush,
    output logic                   o_tlb_miss,
    output logic [VADDR_WIDTH-1:0] o_tlb_miss_vaddr,
    input  logic                   i_ptw_valid,
    input  logic [PADDR_WIDTH-1:0] i_ptw_paddr,
    input  logic [ATTR_WIDTH-1:0]  i_ptw_pte_attr,
    input  logic                   i_page_fault
`ifdef CG_TLB_PERF_CNT_EN
    ,
    output logic [31:0]            o_hit_cnt,
    output logic [31:0]            o_miss_cnt
`endif
);

    // state | meaning
    // IDLE  | accepting requests; hits answered next cycle
    // MISS  | one-cycle miss strobe toward the walker
    // WAIT  | waiting for a walker valid edge or a page fault

    localparam int IDXW = $clog2(ENTRIES);
    localparam int VPNW = VADDR_WIDTH - 12;
    localparam int PPNW = PADDR_WIDTH - 12;

    typedef enum logic [1:0] {IDLE, MISS, WAIT} state_t;

    state_t                state, state_nxt;
    logic [ENTRIES-1:0]    ent_valid;
    logic [VPNW-1:0]       ent_vpn  [ENTRIES];
    logic [PPNW-1:0]       ent_ppn  [ENTRIES];
    logic [ATTR_WIDTH-1:0] ent_attr [ENTRIES];

    logic [IDXW-1:0]        victim_ptr;
    logic [VADDR_WIDTH-1:0] miss_vaddr;
    logic                   ptw_prev;
    logic                   flush_pend;

    logic            hit;
    logic [IDXW-1:0] hit_idx;
    logic            have_free;
    logic [IDXW-1:0] free_idx;
    logic [IDXW-1:0] fill_idx;
    logic            req_ready;
    logic            walk_done;
    logic            walk_fault;
    logic            accept;
    logic            fill_en;
    logic            ptw_edge;

    // Descending scans so the lowest matching / free index wins.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_vpn[i] == i_req_vaddr[VADDR_WIDTH-1:12])) begin
                hit     = 1'b1;
                hit_idx = IDXW'(i);
            end
            if (!ent_valid[i]) begin
                have_free = 1'b1;
                free_idx  = IDXW'(i);
            end
        end
    end

    assign fill_idx = have_free ? free_idx : victim_ptr;
    assign ptw_edge = i_ptw_valid && !ptw_prev;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        walk_done  = 1'b0;
        walk_fault = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (i_req_valid && !hit) state_nxt = MISS;
            end
            MISS: state_nxt = WAIT;
            WAIT: begin
                if (i_page_fault) begin
                    walk_fault = 1'b1;
                    state_nxt  = IDLE;
                end else if (ptw_edge) begin
                    walk_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept           = i_req_valid && req_ready;
    assign fill_en          = walk_done && !i_flush && !flush_pend;
    assign o_req_ready      = req_ready;
    assign o_tlb_miss       = (state == MISS);
    assign o_tlb_miss_vaddr = miss_vaddr;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ent_valid    <= '0;
            victim_ptr   <= '0;
            miss_vaddr   <= '0;
            ptw_prev     <= 1'b1;
            flush_pend   <= 1'b0;
            o_resp_valid <= 1'b0;
            o_resp_paddr <= '0;
            o_resp_attr  <= '0;
            o_resp_fault <= 1'b0;
        end else begin
            o_resp_valid <= 1'b0;
            ptw_prev     <= i_ptw_valid;
            if (accept && hit) begin
                o_resp_valid <= 1'b1;
                o_resp_paddr <= {ent_ppn[hit_idx], i_req_vaddr[11:0]};
                o_resp_attr  <= ent_attr[hit_idx];
                o_resp_fault <= 1'b0;
            end
            if (accept && !hit) miss_vaddr <= i_req_vaddr;
            if (walk_fault) begin
                o_resp_valid <= 1'b1;
                o_resp_fault <= 1'b1;
            end
            if (walk_done) begin
                o_resp_valid <= 1'b1;
                o_resp_paddr <= i_ptw_paddr;
                o_resp_attr  <= i_ptw_pte_attr;
                o_resp_fault <= 1'b0;
            end
            // A flush while the walk is outstanding makes its result stale for caching.
            if (i_flush && (state != IDLE)) flush_pend <= 1'b1;
            if (walk_done || walk_fault)     flush_pend <= 1'b0;
            if (i_flush) begin
                ent_valid <= '0;
            end else if (fill_en) begin
                ent_valid[fill_idx] <= 1'b1;
            end
            if (fill_en) victim_ptr <= victim_ptr + IDXW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (fill_en) begin
            ent_vpn[fill_idx]  <= miss_vaddr[VADDR_WIDTH-1:12];
            ent_ppn[fill_idx]  <= i_ptw_paddr[PADDR_WIDTH-1:12];
            ent_attr[fill_idx] <= i_ptw_pte_attr;
        end
    end

`ifdef CG_TLB_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (accept) begin
            if (hit) o_hit_cnt  <= o_hit_cnt + 32'd1;
            else     o_miss_cnt <= o_miss_cnt + 32'd1;
        end
    end
`endif

endmodule
